// File: rtl/fff_pkg.sv
// Shared types and helpers for the N-player fastest-finger-first arbiter.
package fff_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_WON     = 2'd2,
    ST_TIMEOUT = 2'd3
  } fff_state_e;

  localparam int TIE_FIXED = 0;
  localparam int TIE_RR    = 1;

  // Binary index width, never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fff_sync_edge.sv
// One buzzer channel: multi-stage synchroniser followed by a rising-edge pulse.
module fff_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw button through the chain; keep a one-cycle-old copy of the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // A held level produces exactly one pulse.
  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/fff_arbiter_n.sv
// N-player fastest-finger-first arbiter: synchronised press detection,
// false-start lockout, single-winner latch with tie-break and answer timer.
module fff_arbiter_n
  import fff_pkg::*;
#(
  parameter int N_PLAYERS     = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int ANSWER_CYCLES = 1000,
  parameter int TIE_MODE      = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_PLAYERS-1:0]                buzzer,
  input  logic                                arm,
  input  logic                                clear,
  output logic                                winner_valid,
  output logic [N_PLAYERS-1:0]                winner_onehot,
  output logic [fff_pkg::id_w(N_PLAYERS)-1:0] winner_id,
  output logic [N_PLAYERS-1:0]                false_start,
  output logic                                timeout,
  output logic [STATE_W-1:0]                  state_o
);

  localparam int IDW = fff_pkg::id_w(N_PLAYERS);
  localparam int TW  = (ANSWER_CYCLES < 1) ? 1 : $clog2(ANSWER_CYCLES + 1);

  logic [N_PLAYERS-1:0] press;
  logic [N_PLAYERS-1:0] cand;
  logic                 found;
  logic [IDW-1:0]       gnt_id;
  logic [IDW-1:0]       rr_ptr;
  logic [TW-1:0]        timer;
  fff_state_e           state;
  int                   idx;

  for (genvar i = 0; i < N_PLAYERS; i++) begin : g_sync
    fff_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_se (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (buzzer[i]),
      .rise (press[i])
    );
  end

  assign cand = press & ~false_start;

  // First candidate found walking upward from the start point, wrapping at N-1.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    idx    = 0;
    for (int k = 0; k < N_PLAYERS; k++) begin
      idx = k + ((TIE_MODE == TIE_RR) ? int'(rr_ptr) : 0);
      if (idx >= N_PLAYERS) idx = idx - N_PLAYERS;
      if (!found && cand[idx]) begin
        found  = 1'b1;
        gnt_id = IDW'(idx);
      end
    end
  end

  // Round FSM with registered winner, lockout, timer and pointer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      winner_valid  <= 1'b0;
      winner_onehot <= '0;
      winner_id     <= '0;
      false_start   <= '0;
      timeout       <= 1'b0;
      timer         <= '0;
      rr_ptr        <= '0;
    end else if (clear) begin
      state         <= ST_IDLE;
      winner_valid  <= 1'b0;
      winner_onehot <= '0;
      winner_id     <= '0;
      false_start   <= '0;
      timeout       <= 1'b0;
      timer         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          false_start <= false_start | press;
          if (arm) state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (found) begin
            state         <= ST_WON;
            winner_valid  <= 1'b1;
            winner_onehot <= {{(N_PLAYERS-1){1'b0}}, 1'b1} << gnt_id;
            winner_id     <= gnt_id;
            timer         <= TW'(ANSWER_CYCLES);
            rr_ptr        <= (int'(gnt_id) == N_PLAYERS - 1) ? '0 : gnt_id + 1'b1;
          end
        end
        ST_WON: begin
          if (timer != '0) timer <= timer - 1'b1;
          if (timer == TW'(1)) begin
            state   <= ST_TIMEOUT;
            timeout <= 1'b1;
          end
        end
        ST_TIMEOUT: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_fff_arbiter_n.sv
// Directed bench: fixed-priority instance (dut0) and round-robin instance (dut1)
// share one stimulus stream.
module tb_fff_arbiter_n;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] buzzer = '0;
  logic       arm = 1'b0;
  logic       clear = 1'b0;

  logic       v0, v1, to0, to1;
  logic [3:0] oh0, oh1, fs0, fs1;
  logic [1:0] id0, id1, st0, st1;

  int checks = 0;
  int errors = 0;
  int rr_exp[3] = '{0, 3, 0};

  always #5 clk = ~clk;

  fff_arbiter_n #(.N_PLAYERS(4), .SYNC_STAGES(2), .ANSWER_CYCLES(10), .TIE_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .buzzer(buzzer), .arm(arm), .clear(clear),
    .winner_valid(v0), .winner_onehot(oh0), .winner_id(id0),
    .false_start(fs0), .timeout(to0), .state_o(st0)
  );

  fff_arbiter_n #(.N_PLAYERS(4), .SYNC_STAGES(2), .ANSWER_CYCLES(10), .TIE_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .buzzer(buzzer), .arm(arm), .clear(clear),
    .winner_valid(v1), .winner_onehot(oh1), .winner_id(id1),
    .false_start(fs1), .timeout(to1), .state_o(st1)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic release_btn();
    buzzer = '0; tick(3);
  endtask

  initial begin
    #12 rst_n = 1'b1;
    tick();
    chk("rst_state", st0, 0);
    chk("rst_valid", v0, 0);
    chk("rst_onehot", oh0, 0);
    chk("rst_fs", fs0, 0);
    chk("rst_timeout", to0, 0);

    // basic win, player 2, two-stage latency
    pulse_arm();
    chk("armed_state", st0, 1);
    buzzer = 4'b0100;
    tick();                      // edge t
    tick();                      // edge t+1
    chk("win_not_yet", v0, 0);
    tick();                      // edge t+2
    chk("win_valid", v0, 1);
    chk("win_onehot", oh0, 4'b0100);
    chk("win_id", id0, 2);
    chk("win_state", st0, 2);
    release_btn();
    pulse_clear();
    chk("clr_state", st0, 0);
    chk("clr_valid", v0, 0);

    // false start then lockout, then another player wins
    buzzer = 4'b0010; tick(3);
    chk("fs_set", fs0, 4'b0010);
    release_btn();
    pulse_arm();
    buzzer = 4'b0010; tick(3);
    chk("fs_locked_valid", v0, 0);
    chk("fs_locked_state", st0, 1);
    release_btn();
    buzzer = 4'b1000; tick(3);
    chk("fs_other_id", id0, 3);
    chk("fs_other_valid", v0, 1);
    chk("fs_frozen", fs0, 4'b0010);
    release_btn();
    pulse_clear();
    chk("fs_cleared", fs0, 0);

    // answer timer: timeout exactly 10 cycles after winner_valid rises
    pulse_arm();
    buzzer = 4'b0001; tick(3);
    chk("tmr_win", v0, 1);
    buzzer = '0;
    tick(9);
    chk("tmr_early_to", to0, 0);
    chk("tmr_early_st", st0, 2);
    tick();
    chk("tmr_to", to0, 1);
    chk("tmr_st", st0, 3);
    chk("tmr_valid_kept", v0, 1);
    pulse_clear();
    chk("tmr_clr_to", to0, 0);
    chk("tmr_clr_valid", v0, 0);
    chk("tmr_clr_onehot", oh0, 0);
    chk("tmr_clr_id", id0, 0);
    chk("tmr_clr_st", st0, 0);

    // arm and clear together: clear wins
    arm = 1'b1; clear = 1'b1; tick(); arm = 1'b0; clear = 1'b0;
    chk("armclr_state", st0, 0);

    // held level across arm: no second event
    buzzer = 4'b0100; tick(3);
    chk("held_fs", fs0, 4'b0100);
    pulse_arm();
    tick(4);
    chk("held_valid", v0, 0);
    chk("held_state", st0, 1);
    chk("held_fs_after", fs0, 4'b0100);
    release_btn();
    pulse_clear();

    // round-robin ties from a known pointer
    #2 rst_n = 1'b0; #2 rst_n = 1'b1;
    tick();
    for (int r = 0; r < 3; r++) begin
      pulse_arm();
      buzzer = 4'b1001; tick(3);
      chk("rr_valid", v1, 1);
      chk("rr_id", id1, rr_exp[r]);
      chk("fixed_tie_id", id0, 0);
      if (r < 2) begin
        release_btn();
        pulse_clear();
      end
    end

    // async reset while in WON, checked before the next edge
    chk("pre_rst_state", st1, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", v1, 0);
    chk("arst_onehot", oh1, 0);
    chk("arst_state", st1, 0);
    chk("arst_state0", st0, 0);
    buzzer = '0;
    #2 rst_n = 1'b1;
    tick(3);
    pulse_arm();
    buzzer = 4'b1001; tick(3);
    chk("post_rst_rr_id", id1, 0);
    chk("post_rst_rr_valid", v1, 1);
    release_btn();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fff_arbiter_n.md
Name: fff_arbiter_n

Overview:
Parametrised N-player fastest-finger-first arbiter, successor to the two-player buzzer block. Synchronises and edge-detects every buzzer, and accepts presses only while the host has armed the round. It latches a single winner with a deterministic tie-break, flags false starts, and times the winner's answer window. Sits between the debounced player buttons and the host/scoreboard logic.

Parameters:
N_PLAYERS, 4, number of buzzer channels (2..16).
SYNC_STAGES, 2, flip-flop stages per buzzer synchroniser (>=2).
ANSWER_CYCLES, 1000, clock cycles the winner has to answer; 0 disables the timer.
TIE_MODE, 0, tie-break rule: 0 = fixed priority, lowest index wins; 1 = round-robin.

Ports:
clk  in  1  system clock; all logic on its rising edge
rst_n  in  1  asynchronous, active-low reset
buzzer  in  N_PLAYERS  raw player buttons, asynchronous, active-high
arm  in  1  host pulse: open the round
clear  in  1  host pulse: end the round, return to IDLE
winner_valid  out  1  a winner is latched
winner_onehot  out  N_PLAYERS  one-hot winner; all zero when no winner
winner_id  out  max(1,$clog2(N_PLAYERS))  binary winner index; 0 when no winner
false_start  out  N_PLAYERS  sticky per-player lockout flags
timeout  out  1  answer window expired
state_o  out  2  IDLE=0, ARMED=1, WON=2, TIMEOUT=3

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE, all outputs 0, synchronisers 0, edge-history 0, round-robin pointer 0, timer 0.
- Press event: a 0->1 transition on the synchronised buzzer, sync output vs its one-cycle-delayed copy.
  - Buzzer first sampled high at edge t; the FSM acts on it at edge t+SYNC_STAGES.
  - A held level never generates a second event.
- IDLE:
  - Press event on player i sets false_start[i]; it stays set until clear or reset.
  - arm -> ARMED.
  - A press event in the same cycle as arm counts as a false start.
- ARMED:
  - Candidate set = press events AND NOT false_start.
  - If the set is non-empty: grant one player per TIE_MODE, then -> WON.
    - winner_onehot/winner_id/winner_valid are registered on the transition edge.
    - Timer loads ANSWER_CYCLES.
  - TIE_MODE=1: search starts at the pointer and wraps at N_PLAYERS-1 -> 0. On every grant the pointer becomes (winner+1) mod N_PLAYERS.
  - arm is ignored.
  - If every player is locked out, the FSM stays ARMED until clear.
- WON:
  - Winner outputs hold; all further presses are ignored.
  - False-start flags are frozen.
  - Timer decrements once per cycle. When the timer is 1 and decrementing, -> TIMEOUT on the next edge, so timeout rises exactly ANSWER_CYCLES cycles after winner_valid rises.
  - ANSWER_CYCLES=0: stay in WON until clear.
- TIMEOUT: timeout=1; winner outputs remain valid; presses are ignored.
- clear (any state) -> IDLE on the next edge.
  - Clears winner outputs, false_start, timeout and timer.
  - Keeps the round-robin pointer.
- clear and arm in the same cycle: clear wins, arm is dropped.
- arm in WON/TIMEOUT: ignored.
- Reset mid-round: immediate return to reset values, including the pointer.
- Timer width is $clog2(ANSWER_CYCLES+1); no wrap. The counter saturates at 0.

Decomposition:
- Package fff_pkg:
  - state enum (IDLE/ARMED/WON/TIMEOUT, 2-bit).
  - STATE_W constant.
  - TIE_FIXED/TIE_RR constants.
  - id-width function max(1,$clog2(n)).
- Sub-module fff_sync_edge: SYNC_STAGES synchroniser plus rising-edge pulse for one buzzer, instantiated N_PLAYERS times in a generate loop.
- Arbitration (priority/rotating search) and the FSM stay in the top module.

Test Plan:
- N=4, TIE_MODE=0, arm, then buzzer[2] high at edge t -> at edge t+2: winner_valid=1, winner_onehot=4'b0100, winner_id=2, state_o=2.
- Buzzer[1] pressed in IDLE, then arm, then buzzer[1] re-pressed -> false_start=4'b0010, no winner. Then buzzer[3] pressed -> winner_id=3.
- TIE_MODE=1, buzzers 0 and 3 sampled high on the same edge, three consecutive rounds with clear between:
  - round 1 winner 0, pointer -> 1;
  - round 2 winner 3, pointer -> 0;
  - round 3 winner 0.
- ANSWER_CYCLES=10, a win occurs -> timeout=1 and state_o=3 exactly 10 cycles after winner_valid rose. clear -> all outputs 0, state_o=0.
- arm and clear asserted together in IDLE -> state stays 0. Buzzer held high across arm -> no win and no false start after arm.
- rst_n pulsed low asynchronously while in WON -> outputs 0 immediately, without waiting for a clock edge. After release, TIE_MODE=1 with a 0/3 tie grants player 0.
